gomoku_ai_scan: RTL and testbench
=================================

Name: gomoku_ai_scan

Overview:
- Parametrised greedy move selector for the gobang AI: given the human and AI stone bitmaps, it chooses the AI's next move.
- Scans every cell of an N×N board at one cell per clock through a 2-stage scoring pipeline, keeping the best attack cell and the best defence cell.
- Sits between the game controller and the board register.
- Over the previous fixed 15×15 selector it adds:
  - a parametrised board size;
  - board latching at start;
  - a start/done handshake;
  - an aggressive mode and an immediate-win override;
  - illegal-board and full-board reporting.

Parameters:
N, 15, board side length (5..15)
COORD_W, 4, width of move_x/move_y (>= clog2(N))
IDX_W, 8, width of move_idx (>= clog2(N*N))
SCORE_W, 20, width of summed scores (holds 4×100000)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  request a move; sampled only in IDLE
aggressive  in  1  1 = prefer attack on equal scores
human_in  in  N*N  human stones, bit = row*N+col; latched on start
ai_in  in  N*N  AI stones, same layout; latched on start
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse, result valid
move_valid  out  1  move_x/move_y/move_idx hold a legal move
move_x  out  COORD_W  row of the chosen cell
move_y  out  COORD_W  column of the chosen cell
move_idx  out  IDX_W  row*N+col
no_move  out  1  board full
err  out  1  some cell is set in both bitmaps
score_ai  out  SCORE_W  AI score of the chosen cell
score_hm  out  SCORE_W  human score of the chosen cell

Behaviour:
Reset and output holding
- On reset, all outputs go to 0 and the FSM enters IDLE. Reset overrides everything.
- A reset mid-scan aborts the scan with no done pulse.
- Result outputs hold their values until the next accepted start. At that start, move_valid, no_move and err clear.
- busy and done are never high in the same cycle.

FSM states: IDLE, CHECK, SCAN, DRAIN, DECIDE.
- IDLE: when start=1, latch both bitmaps and go to CHECK. When start=0, stay.
- CHECK (1 cycle):
  - If any cell is set in both bitmaps: err=1, done pulses on the next cycle, return to IDLE.
  - Else if both bitmaps are all zero: move = centre (N/2, N/2), move_valid=1, done pulses on the next cycle.
  - Otherwise go to SCAN with idx=0.
- SCAN: idx advances by 1 per cycle from 0 to N*N-1, feeding the pipeline. Then go to DRAIN.
- DRAIN: 2 cycles, to flush the pipeline stages.
- DECIDE: 1 cycle; the result is registered and done pulses on the following edge. Return to IDLE.
- Latency: done rises exactly N*N+4 clock edges after the edge that sampled start (229 for N=15). For the err and empty-board paths it is 2 edges.
- start while busy is ignored. Input changes while busy have no effect.

Cell scoring
- Only empty cells are scored; occupied cells are skipped and never selected.
- For each side S (AI, human) and each of 4 directions (row, column, down-right diagonal, down-left diagonal), treat the target as an S stone:
  - L = contiguous S run through the target, looking at most 4 cells each way, capped at 5.
  - E = number of run ends (0..2) whose next cell is on-board and empty. Off-board cells and opponent stones count as blocked.
- Direction value:
  - L>=5: 100000
  - L=4: E=2 → 10000, E=1 → 1000
  - L=3: E=2 → 1000, E=1 → 100
  - L=2: E=2 → 100, E=1 → 10
  - L=1: E=2 → 10, E=1 → 1
  - E=0 with L<5: 0
- Side score = sum of its 4 direction values. Arithmetic is unsigned and cannot overflow SCORE_W.
- Pipeline:
  - Stage 1 registers the window extraction and the L/E values per direction and side.
  - Stage 2 registers the sums.
  - The compare uses the stage-2 outputs.

Tracking
- Best-attack cell: maximise AI score; ties broken by higher human score, then by lowest idx (strict > replaces).
- Best-defence cell: maximise human score; ties broken by higher AI score, then by lowest idx.
- The first empty cell initialises both trackers.

Decision
- If no empty cell was found: no_move=1, move_valid=0.
- Else choose attack if any of these holds:
  - max_ai >= 100000;
  - aggressive=1 and max_ai >= max_hm;
  - aggressive=0 and max_ai > max_hm.
- Otherwise choose defence.
- move_valid=1. score_ai and score_hm are those of the chosen cell.

Test Plan:
- N=15, ai stones at (7,5..8), human stones at (0,0..3), aggressive=0, start → done at edge 229; move (7,4), idx 109, score_ai=100030, score_hm=31, move_valid=1.
- N=15, human open three at (7,6..8), ai stone at (0,0), aggressive=0 → defence move (7,5), idx 110, score_hm=10030.
- Both boards empty, N=15 → move (7,7) with done 2 edges after start. Repeat with N=9 → (4,4).
- Bit 0 set in both bitmaps → err=1, move_valid=0, done 2 edges after start. Next start with a legal board clears err.
- Board fully occupied without overlap → no_move=1, move_valid=0, done at edge 229.
- Pulse start again at edge 50 of a scan, and assert reset at edge 100 of another scan → the second start is ignored. Reset returns all outputs to 0 with no done pulse, and a fresh start completes normally.

Source files
------------

// File: rtl/gomoku_ai_scan.sv
// Greedy gobang move selector: latches both stone bitmaps on start, scores
// every empty cell through a 2-stage pipeline (one cell per clock), tracks
// the best attack and best defence cells and registers the chosen move.
module gomoku_ai_scan #(
   parameter int N       = 15,
   parameter int COORD_W = 4,
   parameter int IDX_W   = 8,
   parameter int SCORE_W = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               aggressive,
   input  logic [N*N-1:0]     human_in,
   input  logic [N*N-1:0]     ai_in,
   output logic               busy,
   output logic               done,
   output logic               move_valid,
   output logic [COORD_W-1:0] move_x,
   output logic [COORD_W-1:0] move_y,
   output logic [IDX_W-1:0]   move_idx,
   output logic               no_move,
   output logic               err,
   output logic [SCORE_W-1:0] score_ai,
   output logic [SCORE_W-1:0] score_hm
);

   localparam int CELLS = N * N;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CHECK  = 3'd1;
   localparam logic [2:0] S_SCAN   = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_DECIDE = 3'd4;

   localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(100000);

   // ---------------------------------------------------------------------
   // Scoring helpers
   // ---------------------------------------------------------------------
   function automatic logic on_board(input int rr, input int cc);
      return (rr >= 0) && (rr < N) && (cc >= 0) && (cc < N);
   endfunction

   // One-hot mask test keeps the lookup free of variable-width indexing;
   // off-board coordinates are screened by on_board before use.
   function automatic logic bit_at(input logic [CELLS-1:0] v, input int rr, input int cc);
      logic [CELLS-1:0] mask;
      mask = CELLS'(1) << unsigned'(rr * N + cc);
      return on_board(rr, cc) && ((v & mask) != '0);
   endfunction

   // Run length through the target (capped at 5) and number of open ends,
   // packed as {L[2:0], E[1:0]}.
   function automatic logic [4:0] dir_eval(input logic [CELLS-1:0] own,
                                           input logic [CELLS-1:0] opp,
                                           input int r, input int c,
                                           input int dr, input int dc);
      int   f, b, len, e;
      logic run;
      f   = 0;
      run = 1'b1;
      for (int unsigned k = 1; k <= 4; k++) begin
         if (run && bit_at(own, r + int'(k) * dr, c + int'(k) * dc)) f++;
         else run = 1'b0;
      end
      b   = 0;
      run = 1'b1;
      for (int unsigned k = 1; k <= 4; k++) begin
         if (run && bit_at(own, r - int'(k) * dr, c - int'(k) * dc)) b++;
         else run = 1'b0;
      end
      len = 1 + f + b;
      if (len > 5) len = 5;
      e = 0;
      if (on_board(r + (f + 1) * dr, c + (f + 1) * dc) &&
          !bit_at(own, r + (f + 1) * dr, c + (f + 1) * dc) &&
          !bit_at(opp, r + (f + 1) * dr, c + (f + 1) * dc)) e++;
      if (on_board(r - (b + 1) * dr, c - (b + 1) * dc) &&
          !bit_at(own, r - (b + 1) * dr, c - (b + 1) * dc) &&
          !bit_at(opp, r - (b + 1) * dr, c - (b + 1) * dc)) e++;
      return {3'(len), 2'(e)};
   endfunction

   function automatic logic [SCORE_W-1:0] dir_val(input logic [4:0] le);
      logic [2:0] len;
      logic [1:0] e;
      logic [SCORE_W-1:0] v;
      len = le[4:2];
      e   = le[1:0];
      v   = '0;
      if (len >= 3'd5) v = WIN_SCORE;
      else if (e != 2'd0) begin
         case (len)
            3'd4:    v = (e == 2'd2) ? SCORE_W'(10000) : SCORE_W'(1000);
            3'd3:    v = (e == 2'd2) ? SCORE_W'(1000)  : SCORE_W'(100);
            3'd2:    v = (e == 2'd2) ? SCORE_W'(100)   : SCORE_W'(10);
            3'd1:    v = (e == 2'd2) ? SCORE_W'(10)    : SCORE_W'(1);
            default: v = '0;
         endcase
      end
      return v;
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [2:0]         state_q, state_d;
   logic [CELLS-1:0]   hum_q, hum_d, ai_q, ai_d;
   logic               aggr_q, aggr_d;
   logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
   logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
   logic               drain_q, drain_d;
   logic               fast_err_q, fast_err_d, fast_ctr_q, fast_ctr_d;

   logic               v1_q, v1_d;
   logic [COORD_W-1:0] r1_q, r1_d, c1_q, c1_d;
   logic [IDX_W-1:0]   i1_q, i1_d;
   logic [3:0][4:0]    lea_q, lea_d, leh_q, leh_d;

   logic               v2_q, v2_d;
   logic [COORD_W-1:0] r2_q, r2_d, c2_q, c2_d;
   logic [IDX_W-1:0]   i2_q, i2_d;
   logic [SCORE_W-1:0] sa2_q, sa2_d, sh2_q, sh2_d;

   logic               have_q, have_d;
   logic [SCORE_W-1:0] at_ai_q, at_ai_d, at_hm_q, at_hm_d;
   logic [COORD_W-1:0] at_r_q, at_r_d, at_c_q, at_c_d;
   logic [IDX_W-1:0]   at_i_q, at_i_d;
   logic [SCORE_W-1:0] df_ai_q, df_ai_d, df_hm_q, df_hm_d;
   logic [COORD_W-1:0] df_r_q, df_r_d, df_c_q, df_c_d;
   logic [IDX_W-1:0]   df_i_q, df_i_d;

   logic               done_q, done_d, mv_q, mv_d, nomove_q, nomove_d, err_q, err_d;
   logic [COORD_W-1:0] mx_q, mx_d, my_q, my_d;
   logic [IDX_W-1:0]   midx_q, midx_d;
   logic [SCORE_W-1:0] sai_q, sai_d, shm_q, shm_d;
   logic               cell_empty, pick_att;

   // Stage 1: run/open-end extraction for the cell under the scan pointer
   always_comb begin
      cell_empty = !bit_at(hum_q | ai_q, int'(row_q), int'(col_q));
      v1_d = (state_q == S_SCAN) && cell_empty;
      r1_d = row_q;
      c1_d = col_q;
      i1_d = scan_idx_q;
      lea_d[0] = dir_eval(ai_q, hum_q, int'(row_q), int'(col_q), 0, 1);
      lea_d[1] = dir_eval(ai_q, hum_q, int'(row_q), int'(col_q), 1, 0);
      lea_d[2] = dir_eval(ai_q, hum_q, int'(row_q), int'(col_q), 1, 1);
      lea_d[3] = dir_eval(ai_q, hum_q, int'(row_q), int'(col_q), 1, -1);
      leh_d[0] = dir_eval(hum_q, ai_q, int'(row_q), int'(col_q), 0, 1);
      leh_d[1] = dir_eval(hum_q, ai_q, int'(row_q), int'(col_q), 1, 0);
      leh_d[2] = dir_eval(hum_q, ai_q, int'(row_q), int'(col_q), 1, 1);
      leh_d[3] = dir_eval(hum_q, ai_q, int'(row_q), int'(col_q), 1, -1);
   end

   // Stage 2: direction values summed per side
   always_comb begin
      v2_d  = v1_q;
      r2_d  = r1_q;
      c2_d  = c1_q;
      i2_d  = i1_q;
      sa2_d = '0;
      sh2_d = '0;
      for (int unsigned d = 0; d < 4; d++) begin
         sa2_d = sa2_d + dir_val(lea_q[d]);
         sh2_d = sh2_d + dir_val(leh_q[d]);
      end
   end

   // Best-attack / best-defence trackers fed by stage 2 (strict > keeps lowest idx)
   always_comb begin
      have_d  = have_q;
      at_ai_d = at_ai_q; at_hm_d = at_hm_q; at_r_d = at_r_q; at_c_d = at_c_q; at_i_d = at_i_q;
      df_ai_d = df_ai_q; df_hm_d = df_hm_q; df_r_d = df_r_q; df_c_d = df_c_q; df_i_d = df_i_q;
      if (state_q == S_CHECK) begin
         have_d = 1'b0;
      end else if (v2_q) begin
         have_d = 1'b1;
         if (!have_q || (sa2_q > at_ai_q) || ((sa2_q == at_ai_q) && (sh2_q > at_hm_q))) begin
            at_ai_d = sa2_q; at_hm_d = sh2_q; at_r_d = r2_q; at_c_d = c2_q; at_i_d = i2_q;
         end
         if (!have_q || (sh2_q > df_hm_q) || ((sh2_q == df_hm_q) && (sa2_q > df_ai_q))) begin
            df_ai_d = sa2_q; df_hm_d = sh2_q; df_r_d = r2_q; df_c_d = c2_q; df_i_d = i2_q;
         end
      end
   end

   // Control FSM, board latch and registered result
   always_comb begin
      state_d    = state_q;
      hum_d      = hum_q;
      ai_d       = ai_q;
      aggr_d     = aggr_q;
      scan_idx_d = scan_idx_q;
      row_d      = row_q;
      col_d      = col_q;
      drain_d    = drain_q;
      fast_err_d = fast_err_q;
      fast_ctr_d = fast_ctr_q;
      done_d     = 1'b0;
      mv_d       = mv_q;
      nomove_d   = nomove_q;
      err_d      = err_q;
      mx_d       = mx_q;
      my_d       = my_q;
      midx_d     = midx_q;
      sai_d      = sai_q;
      shm_d      = shm_q;
      pick_att   = (at_ai_q >= WIN_SCORE) ||
                   (aggr_q ? (at_ai_q >= df_hm_q) : (at_ai_q > df_hm_q));
      case (state_q)
         S_IDLE: begin
            if (start) begin
               hum_d    = human_in;
               ai_d     = ai_in;
               aggr_d   = aggressive;
               mv_d     = 1'b0;
               nomove_d = 1'b0;
               err_d    = 1'b0;
               state_d  = S_CHECK;
            end
         end
         S_CHECK: begin
            fast_err_d = (hum_q & ai_q) != '0;
            fast_ctr_d = ((hum_q & ai_q) == '0) && ((hum_q | ai_q) == '0);
            scan_idx_d = '0;
            row_d      = '0;
            col_d      = '0;
            state_d    = (fast_err_d || fast_ctr_d) ? S_DECIDE : S_SCAN;
         end
         S_SCAN: begin
            if (scan_idx_q == IDX_W'(CELLS - 1)) begin
               drain_d = 1'b0;
               state_d = S_DRAIN;
            end else begin
               scan_idx_d = scan_idx_q + 1'b1;
               if (col_q == COORD_W'(N - 1)) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            drain_d = 1'b1;
            if (drain_q) state_d = S_DECIDE;
         end
         S_DECIDE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (fast_err_q) begin
               err_d = 1'b1;
            end else if (fast_ctr_q) begin
               mv_d   = 1'b1;
               mx_d   = COORD_W'(N / 2);
               my_d   = COORD_W'(N / 2);
               midx_d = IDX_W'((N / 2) * N + N / 2);
               sai_d  = '0;
               shm_d  = '0;
            end else if (!have_q) begin
               nomove_d = 1'b1;
            end else if (pick_att) begin
               mv_d = 1'b1; mx_d = at_r_q; my_d = at_c_q; midx_d = at_i_q;
               sai_d = at_ai_q; shm_d = at_hm_q;
            end else begin
               mv_d = 1'b1; mx_d = df_r_q; my_d = df_c_q; midx_d = df_i_q;
               sai_d = df_ai_q; shm_d = df_hm_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // All state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE; hum_q <= '0; ai_q <= '0; aggr_q <= 1'b0;
         scan_idx_q <= '0; row_q <= '0; col_q <= '0; drain_q <= 1'b0;
         fast_err_q <= 1'b0; fast_ctr_q <= 1'b0;
         v1_q <= 1'b0; r1_q <= '0; c1_q <= '0; i1_q <= '0; lea_q <= '0; leh_q <= '0;
         v2_q <= 1'b0; r2_q <= '0; c2_q <= '0; i2_q <= '0; sa2_q <= '0; sh2_q <= '0;
         have_q <= 1'b0;
         at_ai_q <= '0; at_hm_q <= '0; at_r_q <= '0; at_c_q <= '0; at_i_q <= '0;
         df_ai_q <= '0; df_hm_q <= '0; df_r_q <= '0; df_c_q <= '0; df_i_q <= '0;
         done_q <= 1'b0; mv_q <= 1'b0; nomove_q <= 1'b0; err_q <= 1'b0;
         mx_q <= '0; my_q <= '0; midx_q <= '0; sai_q <= '0; shm_q <= '0;
      end else begin
         state_q <= state_d; hum_q <= hum_d; ai_q <= ai_d; aggr_q <= aggr_d;
         scan_idx_q <= scan_idx_d; row_q <= row_d; col_q <= col_d; drain_q <= drain_d;
         fast_err_q <= fast_err_d; fast_ctr_q <= fast_ctr_d;
         v1_q <= v1_d; r1_q <= r1_d; c1_q <= c1_d; i1_q <= i1_d; lea_q <= lea_d; leh_q <= leh_d;
         v2_q <= v2_d; r2_q <= r2_d; c2_q <= c2_d; i2_q <= i2_d; sa2_q <= sa2_d; sh2_q <= sh2_d;
         have_q <= have_d;
         at_ai_q <= at_ai_d; at_hm_q <= at_hm_d; at_r_q <= at_r_d; at_c_q <= at_c_d; at_i_q <= at_i_d;
         df_ai_q <= df_ai_d; df_hm_q <= df_hm_d; df_r_q <= df_r_d; df_c_q <= df_c_d; df_i_q <= df_i_d;
         done_q <= done_d; mv_q <= mv_d; nomove_q <= nomove_d; err_q <= err_d;
         mx_q <= mx_d; my_q <= my_d; midx_q <= midx_d; sai_q <= sai_d; shm_q <= shm_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign move_valid = mv_q;
   assign move_x     = mx_q;
   assign move_y     = my_q;
   assign move_idx   = midx_q;
   assign no_move    = nomove_q;
   assign err        = err_q;
   assign score_ai   = sai_q;
   assign score_hm   = shm_q;

endmodule

// File: tb/tb_gomoku_ai_scan.sv
// Directed self-checking bench for gomoku_ai_scan (N=15 main instance,
// N=9 instance for the centre move of a smaller board).
module tb_gomoku_ai_scan;

   localparam int W  = 225;
   localparam int W9 = 81;

   logic          clk, reset, start, start9, aggressive;
   logic [W-1:0]  human_in, ai_in;
   logic [W9-1:0] hum9, ai9;
   logic          busy, done, move_valid, no_move, err;
   logic [3:0]    move_x, move_y;
   logic [7:0]    move_idx;
   logic [19:0]   score_ai, score_hm;
   logic          busy9, done9, move_valid9, no_move9, err9;
   logic [3:0]    move_x9, move_y9;
   logic [7:0]    move_idx9;
   logic [19:0]   score_ai9, score_hm9;

   int checks   = 0;
   int failures = 0;
   int edges;
   int seen;
   logic [W-1:0] h, a;

   gomoku_ai_scan #(.N(15), .COORD_W(4), .IDX_W(8), .SCORE_W(20)) dut (
      .clk(clk), .reset(reset), .start(start), .aggressive(aggressive),
      .human_in(human_in), .ai_in(ai_in), .busy(busy), .done(done),
      .move_valid(move_valid), .move_x(move_x), .move_y(move_y),
      .move_idx(move_idx), .no_move(no_move), .err(err),
      .score_ai(score_ai), .score_hm(score_hm));

   gomoku_ai_scan #(.N(9), .COORD_W(4), .IDX_W(8), .SCORE_W(20)) dut9 (
      .clk(clk), .reset(reset), .start(start9), .aggressive(aggressive),
      .human_in(hum9), .ai_in(ai9), .busy(busy9), .done(done9),
      .move_valid(move_valid9), .move_x(move_x9), .move_y(move_y9),
      .move_idx(move_idx9), .no_move(no_move9), .err(err9),
      .score_ai(score_ai9), .score_hm(score_hm9));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] onehot(input int r, input int c);
      return W'(1) << (r * 15 + c);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Pulse start across one edge; returns 1 time unit after that edge.
   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Count edges until done is seen, bounded.
   task automatic wait_done(input int budget, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!done && n < budget);
   endtask

   task automatic chk_move(input string tag, input int x, input int y, input int idx,
                           input int sa, input int sh);
      chk({tag, "_valid"}, 32'(move_valid), 1);
      chk({tag, "_x"}, 32'(move_x), x);
      chk({tag, "_y"}, 32'(move_y), y);
      chk({tag, "_idx"}, 32'(move_idx), idx);
      chk({tag, "_score_ai"}, 32'(score_ai), sa);
      chk({tag, "_score_hm"}, 32'(score_hm), sh);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; start9 = 1'b0; aggressive = 1'b0;
      human_in = '0; ai_in = '0; hum9 = '0; ai9 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_valid", 32'(move_valid), 0);
      chk("rst_idx", 32'(move_idx), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_score_ai", 32'(score_ai), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // AI four at (7,5..8): completing the five wins
      a = '0; h = '0;
      for (int c = 5; c <= 8; c++) a = a | onehot(7, c);
      for (int c = 0; c <= 3; c++) h = h | onehot(0, c);
      ai_in = a; human_in = h;
      pulse_start();
      chk("t1_busy", 32'(busy), 1);
      human_in = '0; ai_in = '0;
      wait_done(300, edges);
      chk("t1_latency", edges, 229);
      chk("t1_busy_at_done", 32'(busy), 0);
      chk_move("t1", 7, 4, 109, 100030, 31);
      chk("t1_err", 32'(err), 0);
      chk("t1_no_move", 32'(no_move), 0);
      @(posedge clk); #1;
      chk("t1_done_one_cycle", 32'(done), 0);

      // Human open three at (7,6..8): block it; second start at edge 50 ignored
      a = onehot(0, 0); h = '0;
      for (int c = 6; c <= 8; c++) h = h | onehot(7, c);
      ai_in = a; human_in = h;
      pulse_start();
      repeat (49) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("t2_busy_at_50", 32'(busy), 1);
      wait_done(300, edges);
      chk("t2_latency", edges + 50, 229);
      chk_move("t2", 7, 5, 110, 31, 10030);
      @(posedge clk); #1;

      // Equal maxima (130 vs 130): defence unless aggressive
      ai_in = onehot(7, 7); human_in = onehot(2, 2);
      aggressive = 1'b0;
      pulse_start();
      wait_done(300, edges);
      chk("tie_def_latency", edges, 229);
      chk_move("tie_def", 1, 1, 16, 31, 130);
      aggressive = 1'b1;
      pulse_start();
      aggressive = 1'b0;
      wait_done(300, edges);
      chk_move("tie_att", 6, 6, 96, 130, 31);

      // Empty boards take the centre
      ai_in = '0; human_in = '0;
      pulse_start();
      wait_done(300, edges);
      chk("empty15_latency", edges, 2);
      chk("empty15_valid", 32'(move_valid), 1);
      chk("empty15_x", 32'(move_x), 7);
      chk("empty15_y", 32'(move_y), 7);
      chk("empty15_idx", 32'(move_idx), 112);
      start9 = 1'b1;
      @(posedge clk); #1;
      start9 = 1'b0;
      edges = 0;
      do begin
         @(posedge clk); #1;
         edges++;
      end while (!done9 && edges < 50);
      chk("empty9_latency", edges, 2);
      chk("empty9_valid", 32'(move_valid9), 1);
      chk("empty9_x", 32'(move_x9), 4);
      chk("empty9_y", 32'(move_y9), 4);
      chk("empty9_idx", 32'(move_idx9), 40);

      // Overlapping stones at bit 0
      ai_in = onehot(0, 0); human_in = onehot(0, 0) | onehot(3, 3);
      pulse_start();
      wait_done(300, edges);
      chk("err_latency", edges, 2);
      chk("err_flag", 32'(err), 1);
      chk("err_valid", 32'(move_valid), 0);

      // Legal board afterwards clears err at the accepted start
      a = '0; h = '0;
      for (int c = 5; c <= 8; c++) a = a | onehot(7, c);
      for (int c = 0; c <= 3; c++) h = h | onehot(0, c);
      ai_in = a; human_in = h;
      pulse_start();
      chk("clr_err_at_start", 32'(err), 0);
      chk("clr_valid_at_start", 32'(move_valid), 0);
      wait_done(300, edges);
      chk("clr_latency", edges, 229);
      chk("clr_idx", 32'(move_idx), 109);

      // Full board, no overlap
      a = '0;
      for (int i = 0; i < W; i++) if (i % 2 == 1) a = a | (W'(1) << i);
      ai_in = a; human_in = ~a;
      pulse_start();
      wait_done(300, edges);
      chk("full_latency", edges, 229);
      chk("full_no_move", 32'(no_move), 1);
      chk("full_valid", 32'(move_valid), 0);
      chk("full_err", 32'(err), 0);

      // Reset at edge 100 of a scan aborts it silently
      ai_in = onehot(7, 7); human_in = onehot(2, 2);
      pulse_start();
      repeat (99) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_no_move", 32'(no_move), 0);
      chk("abort_x", 32'(move_x), 0);
      chk("abort_idx", 32'(move_idx), 0);
      chk("abort_score_hm", 32'(score_hm), 0);
      reset = 1'b0;
      seen = 0;
      repeat (240) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("abort_no_done", seen, 0);

      // Fresh start after the abort
      ai_in = a & '0;
      a = '0; h = '0;
      for (int c = 5; c <= 8; c++) a = a | onehot(7, c);
      for (int c = 0; c <= 3; c++) h = h | onehot(0, c);
      ai_in = a; human_in = h;
      pulse_start();
      wait_done(300, edges);
      chk("fresh_latency", edges, 229);
      chk_move("fresh", 7, 4, 109, 100030, 31);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
